stl_rshift_pipe: RTL and testbench

Pipelined, handshaked rotate/shift engine over a vector of `DIM_N` elements of `DAT_W` bits. Direction (left/right) and, optionally, rotate versus zero-fill are selected per transaction. The block replaces the purely combinational element rotator in datapaths that need timing closure at wide `DIM_N`. It sits between a producer and consumer that use valid/ready streaming, and carries a user sideband through the pipe.

---
 rtl/stl_rshift_pkg.sv | 15 +
 rtl/stl_rshift_if.sv | 29 ++
 rtl/stl_rshift_stage.sv | 112 +++++++++++
 rtl/stl_rshift_pipe.sv | 70 +++++++
 tb/tb_stl_rshift_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stl_rshift_pkg.sv
// Shared types and helpers for the pipelined element rotate/shift engine.
package stl_rshift_pkg;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;
  typedef enum logic {MODE_LOGIC = 1'b0, MODE_ROT = 1'b1} mode_e;

  // Number of registered barrel stages, i.e. accept-to-valid latency.
  function automatic int popcount(input logic [31:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/stl_rshift_if.sv
// Valid/ready stream bundle for stl_rshift_pipe; slave = engine, master = producer/consumer.
interface stl_rshift_if #(
  parameter int DIM_N = 16,
  parameter int DAT_W = 10,
  parameter int SHT_W = 4,
  parameter int USR_W = 1
);
  logic                             vld_i;
  logic                             rdy_o;
  logic [DIM_N-1:0][DAT_W-1:0]      data_i;
  logic [SHT_W-1:0]                 shft;
  logic                             dir_i;
  logic                             rot_i;
  logic [USR_W-1:0]                 usr_i;
  logic                             vld_o;
  logic                             rdy_i;
  logic [DIM_N-1:0][DAT_W-1:0]      data_o;
  logic [USR_W-1:0]                 usr_o;

  modport slave (
    input  vld_i, data_i, shft, dir_i, rot_i, usr_i, rdy_i,
    output rdy_o, vld_o, data_o, usr_o
  );

  modport master (
    output vld_i, data_i, shft, dir_i, rot_i, usr_i, rdy_i,
    input  rdy_o, vld_o, data_o, usr_o
  );
endinterface

// File: rtl/stl_rshift_stage.sv
// One barrel stage: moves elements by DIST when its shift bit is set, optionally registered.
// STL_RSHIFT_LOGIC_EN builds the zero-fill path; otherwise the stage is rotate-only.
module stl_rshift_stage
  import stl_rshift_pkg::*;
#(
  parameter int DIM_N = 16,
  parameter int DAT_W = 10,
  parameter int SHT_W = 4,
  parameter int USR_W = 1,
  parameter int DIST  = 1,
  parameter bit REG   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vld_i,
  output logic                        rdy_o,
  input  logic [DIM_N-1:0][DAT_W-1:0] data_i,
  input  logic [SHT_W-1:0]            shft_i,
  input  dir_e                        dir_i,
  input  mode_e                       rot_i,
  input  logic [USR_W-1:0]            usr_i,
  output logic                        vld_o,
  input  logic                        rdy_i,
  output logic [DIM_N-1:0][DAT_W-1:0] data_o,
  output logic [SHT_W-1:0]            shft_o,
  output dir_e                        dir_o,
  output mode_e                       rot_o,
  output logic [USR_W-1:0]            usr_o
);

  localparam int K = $clog2(DIST);

  logic [DIM_N-1:0][DAT_W-1:0] mux;

  // Source indices are compile-time constants; wrap flags mark elements that
  // cross the vector edge and therefore take zero in logical mode.
  for (genvar j = 0; j < DIM_N; j++) begin : g_el
    localparam int LS = (j - DIST + DIM_N) % DIM_N;
    localparam int RS = (j + DIST) % DIM_N;
    localparam bit LW = (j < DIST);
    localparam bit RW = (j + DIST >= DIM_N);
`ifdef STL_RSHIFT_LOGIC_EN
    logic zf;
    assign zf = (rot_i == MODE_LOGIC);
    assign mux[j] = !shft_i[K]           ? data_i[j] :
                    (dir_i == DIR_RIGHT) ? ((RW && zf) ? '0 : data_i[RS]) :
                                           ((LW && zf) ? '0 : data_i[LS]);
`else
    assign mux[j] = !shft_i[K]           ? data_i[j]  :
                    (dir_i == DIR_RIGHT) ? data_i[RS] : data_i[LS];
`endif
  end

  if (REG) begin : g_reg
    logic                        vld_q, vld_d;
    logic [DIM_N-1:0][DAT_W-1:0] data_q, data_d;
    logic [SHT_W-1:0]            shft_q, shft_d;
    dir_e                        dir_q, dir_d;
    mode_e                       rot_q, rot_d;
    logic [USR_W-1:0]            usr_q, usr_d;
    logic                        take;

    // Load when empty or when downstream drains us this cycle.
    assign rdy_o = ~rst & (~vld_q | rdy_i);
    assign take  = rdy_o & vld_i;

    always_comb begin
      vld_d  = rdy_o ? vld_i : vld_q;
      data_d = take ? mux    : data_q;
      shft_d = take ? shft_i : shft_q;
      dir_d  = take ? dir_i  : dir_q;
      rot_d  = take ? rot_i  : rot_q;
      usr_d  = take ? usr_i  : usr_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        shft_q <= '0;
        dir_q  <= DIR_LEFT;
        rot_q  <= MODE_LOGIC;
        usr_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
        shft_q <= shft_d;
        dir_q  <= dir_d;
        rot_q  <= rot_d;
        usr_q  <= usr_d;
      end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign shft_o = shft_q;
    assign dir_o  = dir_q;
    assign rot_o  = rot_q;
    assign usr_o  = usr_q;
  end else begin : g_comb
    logic unused_clkrst;
    assign unused_clkrst = clk ^ rst;
    assign vld_o  = vld_i;
    assign rdy_o  = rdy_i;
    assign data_o = mux;
    assign shft_o = shft_i;
    assign dir_o  = dir_i;
    assign rot_o  = rot_i;
    assign usr_o  = usr_i;
  end

endmodule

// File: rtl/stl_rshift_pipe.sv
// Pipelined handshaked element rotate/shift: SHT_W barrel stages, PIPE_MASK picks registered ones.
// Define STL_RSHIFT_LOGIC_EN to honour rot_i (zero-fill shifts); default build is rotate-only.
module stl_rshift_pipe
  import stl_rshift_pkg::*;
#(
  parameter int               DIM_N     = 16,
  parameter int               DAT_W     = 10,
  parameter int               SHT_W     = 4,
  parameter int               USR_W     = 1,
  parameter logic [SHT_W-1:0] PIPE_MASK = '1
) (
  input logic         clk,
  input logic         rst,
  stl_rshift_if.slave bus
);

  logic                        vld_c  [0:SHT_W];
  logic                        rdy_c  [0:SHT_W];
  logic [DIM_N-1:0][DAT_W-1:0] data_c [0:SHT_W];
  logic [SHT_W-1:0]            shft_c [0:SHT_W];
  dir_e                        dir_c  [0:SHT_W];
  mode_e                       rot_c  [0:SHT_W];
  logic [USR_W-1:0]            usr_c  [0:SHT_W];

  assign vld_c[0]     = bus.vld_i;
  assign data_c[0]    = bus.data_i;
  assign shft_c[0]    = bus.shft;
  assign dir_c[0]     = dir_e'(bus.dir_i);
  assign rot_c[0]     = mode_e'(bus.rot_i);
  assign usr_c[0]     = bus.usr_i;
  assign rdy_c[SHT_W] = bus.rdy_i;

  // Stage k moves by 2^k; ready ripples back from the consumer through every stage.
  for (genvar k = 0; k < SHT_W; k++) begin : g_stg
    stl_rshift_stage #(
      .DIM_N (DIM_N),
      .DAT_W (DAT_W),
      .SHT_W (SHT_W),
      .USR_W (USR_W),
      .DIST  (1 << k),
      .REG   (PIPE_MASK[k])
    ) u_stg (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (vld_c[k]),
      .rdy_o  (rdy_c[k]),
      .data_i (data_c[k]),
      .shft_i (shft_c[k]),
      .dir_i  (dir_c[k]),
      .rot_i  (rot_c[k]),
      .usr_i  (usr_c[k]),
      .vld_o  (vld_c[k+1]),
      .rdy_i  (rdy_c[k+1]),
      .data_o (data_c[k+1]),
      .shft_o (shft_c[k+1]),
      .dir_o  (dir_c[k+1]),
      .rot_o  (rot_c[k+1]),
      .usr_o  (usr_c[k+1])
    );
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{shft_c[SHT_W], dir_c[SHT_W], rot_c[SHT_W]};

  assign bus.rdy_o  = rdy_c[0];
  assign bus.vld_o  = vld_c[SHT_W];
  assign bus.data_o = data_c[SHT_W];
  assign bus.usr_o  = usr_c[SHT_W];

endmodule

// File: tb/tb_stl_rshift_pipe.sv
// Bench for stl_rshift_pipe: directed vector table, multi-cycle sequences, random scoreboard.
module tb_stl_rshift_pipe;
  import stl_rshift_pkg::*;

  localparam int         N  = 8;
  localparam int         W  = 4;
  localparam int         SW = 3;
  localparam int         UW = 8;
  localparam logic [2:0] PM = 3'b111;
  localparam int         L  = popcount(32'(PM));

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t       din;
    logic [2:0] sh;
    logic       dir;
    logic       rot;
    vec_t       exp;
  } vec_rec_t;
  typedef struct {
    vec_t          d;
    logic [UW-1:0] u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  stl_rshift_if #(.DIM_N(N), .DAT_W(W), .SHT_W(SW), .USR_W(UW)) bus ();

  stl_rshift_pipe #(
    .DIM_N(N), .DAT_W(W), .SHT_W(SW), .USR_W(UW), .PIPE_MASK(PM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: per-element source index from the direction/amount rules.
  function automatic vec_t ref_sh(vec_t d, int sh, bit dir, bit rot);
    vec_t r;
    int   src;
`ifndef STL_RSHIFT_LOGIC_EN
    rot = 1'b1;
`endif
    for (int j = 0; j < N; j++) begin
      src = dir ? j + sh : j - sh;
      if (src >= 0 && src < N) r[j] = d[src];
      else                     r[j] = rot ? d[(src + N) % N] : '0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vld_i  = 1'b0;
    bus.data_i = '0;
    bus.shft   = '0;
    bus.dir_i  = 1'b0;
    bus.rot_i  = 1'b1;
    bus.usr_i  = '0;
    bus.rdy_i  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_rec_t tbl [8];
  exp_t     sb [$];
  vec_t     base, snap;
  exp_t     e;
  int       k, got, first, last, nxt, outn, seen;
  bit       prev_stall;
  vec_t     prev_d;
  logic [UW-1:0] prev_u;

  initial begin
    base = 32'h76543210;
    tbl[0] = '{32'h76543210, 3'd3, 1'b0, 1'b1, 32'h43210765};
    tbl[1] = '{32'h76543210, 3'd3, 1'b1, 1'b1, 32'h21076543};
`ifdef STL_RSHIFT_LOGIC_EN
    tbl[2] = '{32'h76543210, 3'd2, 1'b0, 1'b0, 32'h54321000};
    tbl[3] = '{32'h76543210, 3'd7, 1'b1, 1'b0, 32'h00000007};
    tbl[7] = '{32'h76543210, 3'd5, 1'b1, 1'b0, 32'h00000765};
`else
    tbl[2] = '{32'h76543210, 3'd2, 1'b0, 1'b0, 32'h54321076};
    tbl[3] = '{32'h76543210, 3'd7, 1'b1, 1'b0, 32'h65432107};
    tbl[7] = '{32'h76543210, 3'd5, 1'b1, 1'b0, 32'h43210765};
`endif
    tbl[4] = '{32'h76543210, 3'd0, 1'b1, 1'b0, 32'h76543210};
    tbl[5] = '{32'h76543210, 3'd1, 1'b0, 1'b1, 32'h65432107};
    tbl[6] = '{32'hFEDCBA98, 3'd4, 1'b1, 1'b1, 32'hBA98FEDC};

    idle_inputs();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_o", 32'(bus.rdy_o), 0);
    chk("rst_vld_o", 32'(bus.vld_o), 0);
    chk("rst_data_o", 32'(bus.data_o), 0);
    chk("rst_usr_o", 32'(bus.usr_o), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_o", 32'(bus.rdy_o), 1);
    step();

    // Directed vectors: latency, single-cycle pulse, result
    for (int i = 0; i < 8; i++) begin
      bus.vld_i  = 1'b1;
      bus.data_i = tbl[i].din;
      bus.shft   = tbl[i].sh;
      bus.dir_i  = tbl[i].dir;
      bus.rot_i  = tbl[i].rot;
      bus.usr_i  = UW'(8'h10 + i);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(bus.rdy_o), 1);
      step();
      bus.vld_i = 1'b0;
      k = 0;
      for (int t = 1; t <= 10; t++) begin
        @(negedge clk);
        if (bus.vld_o) begin k = t; break; end
      end
      chk($sformatf("vec%0d_lat", i), 32'(k), 32'(L));
      chk($sformatf("vec%0d_data", i), 32'(bus.data_o), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_usr", i), 32'(bus.usr_o), 32'(8'h10 + i));
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), 32'(bus.vld_o), 0);
      step();
    end

    // Back-to-back, shft = usr = 0..7
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 8 + L + 4; c++) begin
      bus.vld_i  = (c < 8);
      bus.data_i = base;
      bus.shft   = 3'(c);
      bus.dir_i  = 1'b0;
      bus.rot_i  = 1'b1;
      bus.usr_i  = UW'(c);
      @(negedge clk);
      if (bus.vld_o) begin
        chk("b2b_usr", 32'(bus.usr_o), 32'(got));
        chk("b2b_data", 32'(bus.data_o), 32'(ref_sh(base, got, 1'b0, 1'b1)));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      step();
    end
    chk("b2b_count", 32'(got), 8);
    chk("b2b_consec", 32'(last - first), 7);

    // Stall then drain, producer holds each item until accepted
    nxt = 0; outn = 0;
    for (int c = 0; c < 40; c++) begin
      bus.rdy_i  = (c >= 6);
      bus.vld_i  = (nxt < 8);
      bus.data_i = base;
      bus.shft   = 3'(nxt);
      bus.dir_i  = 1'b1;
      bus.rot_i  = 1'b1;
      bus.usr_i  = UW'(nxt);
      @(negedge clk);
      if (c == 3) begin
        snap = bus.data_o;
        chk("stall_vld", 32'(bus.vld_o), 1);
      end
      if (c == 4 || c == 5) begin
        chk("stall_hold_data", 32'(bus.data_o), 32'(snap));
        chk("stall_hold_vld", 32'(bus.vld_o), 1);
      end
      if (c == 5) begin
        chk("stall_accepts", 32'(nxt), 3);
        chk("stall_rdy_o", 32'(bus.rdy_o), 0);
      end
      if (bus.vld_o && bus.rdy_i) begin
        chk("drain_usr", 32'(bus.usr_o), 32'(outn));
        chk("drain_data", 32'(bus.data_o), 32'(ref_sh(base, outn, 1'b1, 1'b1)));
        outn++;
      end
      if (bus.vld_i && bus.rdy_o) nxt++;
      step();
      if (outn == 8) break;
    end
    chk("drain_count", 32'(outn), 8);
    bus.vld_i = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.vld_o) seen++;
      step();
    end
    chk("drain_no_dup", 32'(seen), 0);

    // Reset with two in flight
    bus.rdy_i = 1'b1;
    bus.vld_i = 1'b1; bus.usr_i = 8'hA0; bus.shft = 3'd1; bus.data_i = base;
    step();
    bus.usr_i = 8'hA1;
    step();
    bus.vld_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy_o", 32'(bus.rdy_o), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld_o", 32'(bus.vld_o), 0);
    chk("midrst_data_o", 32'(bus.data_o), 0);
    chk("midrst_usr_o", 32'(bus.usr_o), 0);
    seen = 0;
    repeat (6) begin
      step();
      @(negedge clk);
      if (bus.vld_o) seen++;
    end
    chk("midrst_flushed", 32'(seen), 0);
    step();

    // Random traffic against the scoreboard, with stall-stability checks
    prev_stall = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.vld_i  = ($urandom_range(3) != 0);
      bus.data_i = vec_t'($urandom);
      bus.shft   = 3'($urandom_range(7));
      bus.dir_i  = 1'($urandom_range(1));
      bus.rot_i  = 1'($urandom_range(1));
      bus.usr_i  = UW'(c);
      bus.rdy_i  = (c >= 580) || ($urandom_range(3) != 0);
      if (c >= 560) bus.vld_i = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        chk("rnd_stall_vld", 32'(bus.vld_o), 1);
        chk("rnd_stall_data", 32'(bus.data_o), 32'(prev_d));
        chk("rnd_stall_usr", 32'(bus.usr_o), 32'(prev_u));
      end
      prev_stall = bus.vld_o && !bus.rdy_i;
      prev_d     = bus.data_o;
      prev_u     = bus.usr_o;
      if (bus.vld_i && bus.rdy_o)
        sb.push_back('{ref_sh(bus.data_i, int'(bus.shft), bus.dir_i, bus.rot_i), bus.usr_i});
      if (bus.vld_o && bus.rdy_i) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected", 32'(bus.usr_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rnd_usr", 32'(bus.usr_o), 32'(e.u));
          chk("rnd_data", 32'(bus.data_o), 32'(e.d));
        end
      end
      step();
    end
    chk("rnd_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
